// File: rtl/bram_arb_pkg.sv
// Shared constants for the BRAM port arbiter.
// Lock-state encodings and RAM data/byte-enable widths.
package bram_arb_pkg;
  localparam logic [0:0] STATE_UNLOCKED = 1'b0;
  localparam logic [0:0] STATE_LOCKED   = 1'b1;
  localparam int BE_WIDTH   = 4;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Cyclic first-one search starting at ptr.
// Returns one-hot grant, its index and a found flag.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-clock BRAM between requesters.
// Supports a bounded lock so one requester can burst back-to-back.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_REQ    = 2,
  parameter int MAX_LOCK   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*BE_WIDTH-1:0]      req_be,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addra,
  output logic [ADDR_WIDTH-1:0]            ram_addrb,
  output logic [DATA_WIDTH-1:0]            ram_dina,
  output logic [BE_WIDTH-1:0]              ram_wea,
  input  logic [DATA_WIDTH-1:0]            ram_doutb
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [0:0]            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         g;
  logic [IW-1:0]         nxt;
  logic [CW-1:0]         lock_cnt;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_q;
  logic                  pick_any;
  logic                  acc;
  logic                  wr;
  logic                  lk;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] dina_q;
  logic [BE_WIDTH-1:0]   be;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A locked owner blocks everyone else, even while it is idle.
  always_comb begin
    grant = '0;
    g     = pick_idx;
    if (state == STATE_LOCKED) begin
      g            = owner;
      grant[owner] = req_valid[owner];
    end else if (pick_any) begin
      grant = pick_grant;
    end
    if (rst) grant = '0;
  end

  always_comb begin
    addr  = '0;
    wdata = '0;
    be    = '0;
    wr    = 1'b0;
    lk    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        be    = req_be[i*BE_WIDTH +: BE_WIDTH];
        wr    = req_write[i];
        lk    = req_lock[i];
      end
    end
  end

  assign acc       = |grant;
  assign req_ready = grant;
  assign nxt       = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign ram_wea   = (acc && wr) ? be : '0;
  assign ram_addra = (acc && wr) ? addr : addra_q;
  assign ram_dina  = (acc && wr) ? wdata : dina_q;
  assign ram_addrb = (acc && !wr) ? addr : addrb_q;
  assign rsp_valid = rst ? '0 : rsp_q;
  assign rsp_rdata = (|rsp_valid) ? ram_doutb : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STATE_UNLOCKED;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      rsp_q    <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      dina_q   <= '0;
    end else begin
      rsp_q <= (acc && !wr) ? grant : '0;
      if (acc && wr) begin
        addra_q <= addr;
        dina_q  <= wdata;
      end
      if (acc && !wr) addrb_q <= addr;
      if (acc) begin
        if (state == STATE_UNLOCKED) begin
          if (lk && MAX_LOCK > 2) begin
            state    <= STATE_LOCKED;
            owner    <= g;
            lock_cnt <= CW'(1);
          end else begin
            rr_ptr <= nxt;
          end
        end else if (lk && (int'(lock_cnt) + 1 < MAX_LOCK - 1)) begin
          lock_cnt <= lock_cnt + 1'b1;
        end else begin
          state    <= STATE_UNLOCKED;
          lock_cnt <= '0;
          rr_ptr   <= nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed vector table plus random
// traffic checked against a queue/array level reference model.
module tb_bram_port_arbiter;
  localparam int AW = 14;
  localparam int N  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ld;
  logic [1:0]    valid, write, lock;
  logic [2*AW-1:0] addr;
  logic [63:0]   wdata;
  logic [7:0]    be;

  logic [1:0]    rdy0, rdy1, rspv0, rspv1;
  logic [31:0]   rd0, rd1, din0, din1, dout0, dout1;
  logic [AW-1:0] aa0, aa1, ab0, ab1;
  logic [3:0]    we0, we1;

  int total = 0;
  int bad   = 0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(N), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(rdy0),
    .req_write(write), .req_lock(lock), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .rsp_valid(rspv0), .rsp_rdata(rd0),
    .ram_addra(aa0), .ram_addrb(ab0), .ram_dina(din0), .ram_wea(we0),
    .ram_doutb(dout0)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(N), .MAX_LOCK(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(rdy1),
    .req_write(write), .req_lock(lock), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .rsp_valid(rspv1), .rsp_rdata(rd1),
    .ram_addra(aa1), .ram_addrb(ab1), .ram_dina(din1), .ram_wea(we1),
    .ram_doutb(dout1)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'h1122_3344 : (32'hA500_0000 | 32'(i));
  endfunction

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) mem0[i] <= init_val(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem0[aa0[5:0]][8*b +: 8] <= din0[8*b +: 8];
    end
    dout0 <= mem0[ab0[5:0]];
  end

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) mem1[i] <= init_val(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (we1[b]) mem1[aa1[5:0]][8*b +: 8] <= din1[8*b +: 8];
    end
    dout1 <= mem1[ab1[5:0]];
  end

  // reference model state, one set per instance
  int          ptr [2];
  int          own [2];
  int          run [2];
  int          maxl [2];
  logic [1:0]  pv [2];
  logic [31:0] pd [2];
  logic [31:0] rm [2][64];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, w, l,
                       input logic [5:0] a0, a1, input logic [31:0] d0, d1,
                       input logic [3:0] b0, b1);
    rst   = r;
    valid = v;
    write = w;
    lock  = l;
    addr  = {8'h00, a1, 8'h00, a0};
    wdata = {d1, d0};
    be    = {b1, b0};
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [1:0]    o_rdy, o_rsp, er;
      logic [31:0]   o_rd, o_din;
      logic [AW-1:0] o_aa, o_ab, ga;
      logic [3:0]    o_we, ewe;
      logic [31:0]   gd;
      string         p;
      int            g;
      if (k == 0) begin
        o_rdy = rdy0; o_rsp = rspv0; o_rd = rd0; o_din = din0;
        o_aa = aa0; o_ab = ab0; o_we = we0; p = "m16";
      end else begin
        o_rdy = rdy1; o_rsp = rspv1; o_rd = rd1; o_din = din1;
        o_aa = aa1; o_ab = ab1; o_we = we1; p = "m4";
      end
      chk({p, "_rsp_valid"}, 32'(o_rsp), rst ? 32'h0 : 32'(pv[k]));
      chk({p, "_rsp_rdata"}, o_rd, (rst || pv[k] == 2'b00) ? 32'h0 : pd[k]);
      g = -1;
      if (!rst) begin
        if (own[k] >= 0) begin
          if (valid[own[k]]) g = own[k];
        end else begin
          for (int j = 0; j < N; j++) begin
            int c = (ptr[k] + j) % N;
            if (g < 0 && valid[c]) g = c;
          end
        end
      end
      er  = (g >= 0) ? 2'(1 << g) : 2'b00;
      ewe = 4'h0;
      ga  = '0;
      gd  = '0;
      if (g >= 0) begin
        ga = addr[g*AW +: AW];
        gd = wdata[g*32 +: 32];
        if (write[g]) ewe = be[g*4 +: 4];
      end
      chk({p, "_ready"}, 32'(o_rdy), 32'(er));
      chk({p, "_wea"}, 32'(o_we), 32'(ewe));
      if (g >= 0 && write[g]) begin
        chk({p, "_addra"}, 32'(o_aa), 32'(ga));
        chk({p, "_dina"}, o_din, gd);
      end
      if (g >= 0 && !write[g]) chk({p, "_addrb"}, 32'(o_ab), 32'(ga));
      if (rst) begin
        ptr[k] = 0; own[k] = -1; run[k] = 0; pv[k] = 2'b00;
      end else begin
        pv[k] = 2'b00;
        if (g >= 0) begin
          if (!write[g]) begin
            pv[k] = er;
            pd[k] = rm[k][ga[5:0]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (be[g*4+b]) rm[k][ga[5:0]][8*b +: 8] = gd[8*b +: 8];
          end
          if (own[k] < 0) begin
            if (lock[g] && 1 < maxl[k] - 1) begin
              own[k] = g; run[k] = 1;
            end else begin
              ptr[k] = (g + 1) % N;
            end
          end else begin
            run[k]++;
            if (!lock[g] || run[k] >= maxl[k] - 1) begin
              own[k] = -1; run[k] = 0; ptr[k] = (g + 1) % N;
            end
          end
        end
      end
    end
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  v, w, l;
    logic [5:0]  a0, a1;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic [1:0]  er, er4, ers;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [28];

  initial begin
    maxl[0] = 16; maxl[1] = 4;
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0; own[k] = -1; run[k] = 0; pv[k] = 2'b00; pd[k] = '0;
      for (int i = 0; i < 64; i++) rm[k][i] = init_val(i);
    end
    for (int i = 0; i < 28; i++)
      tbl[i] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                 2'b00, 2'b00, 2'b00, 32'h0};
    for (int i = 0; i < 3; i++) tbl[i].r = 1'b1;
    tbl[3].er = 2'b01; tbl[3].er4 = 2'b01;
    tbl[4] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
               2'b10, 2'b10, 2'b01, 32'hA500_0010};
    tbl[5] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
               2'b01, 2'b01, 2'b10, 32'hA500_0020};
    tbl[6] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
               2'b10, 2'b10, 2'b01, 32'hA500_0010};
    tbl[7] = '{1'b0, 2'b01, 2'b01, 2'b00, 6'h05, 6'h20, 32'hAABB_CCDD,
               4'b0101, 2'b01, 2'b01, 2'b10, 32'hA500_0020};
    tbl[8] = '{1'b0, 2'b01, 2'b00, 2'b00, 6'h05, 6'h20, 32'h0, 4'h0,
               2'b01, 2'b01, 2'b00, 32'h0};
    tbl[9] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'h05, 6'h20, 32'h0, 4'h0,
               2'b00, 2'b00, 2'b01, 32'h11BB_33DD};
    for (int i = 10; i < 14; i++) begin
      tbl[i].l = 2'b10; tbl[i].er = 2'b10; tbl[i].er4 = 2'b10;
      tbl[i].ers = 2'b10; tbl[i].erd = 32'hA500_0020;
    end
    tbl[10].ers = 2'b00; tbl[10].erd = 32'h0;
    tbl[13].er4 = 2'b01;
    tbl[14] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b10, 2'b10, 2'b10, 32'hA500_0020};
    tbl[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b01, 2'b01, 2'b10, 32'hA500_0020};
    tbl[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b00, 2'b00, 2'b01, 32'hA500_0010};
    for (int i = 17; i < 22; i++) begin
      tbl[i].l = 2'b01; tbl[i].er = 2'b01; tbl[i].er4 = 2'b01;
      tbl[i].ers = 2'b01; tbl[i].erd = 32'hA500_0010;
    end
    tbl[17].er = 2'b10; tbl[17].er4 = 2'b10;
    tbl[17].ers = 2'b00; tbl[17].erd = 32'h0;
    tbl[18].ers = 2'b10; tbl[18].erd = 32'hA500_0020;
    tbl[21].er4 = 2'b10;
    tbl[22] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b00, 2'b00, 2'b01, 32'hA500_0010};
    tbl[23] = '{1'b0, 2'b10, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b00, 2'b10, 2'b00, 32'h0};
    tbl[24].er = 2'b01; tbl[24].er4 = 2'b01;
    tbl[25].r  = 1'b1;
    tbl[26].er = 2'b01; tbl[26].er4 = 2'b01;
    tbl[27] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'h10, 6'h20, 32'h0, 4'h0,
                2'b00, 2'b00, 2'b01, 32'hA500_0010};

    ld = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 2'b00, 6'h0, 6'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    ld = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].a0, tbl[i].a1,
            tbl[i].d0, ~tbl[i].d0, tbl[i].b0, tbl[i].b0);
      #4;
      chk($sformatf("v%0d_ready", i), 32'(rdy0), 32'(tbl[i].er));
      chk($sformatf("v%0d_ready4", i), 32'(rdy1), 32'(tbl[i].er4));
      chk($sformatf("v%0d_rsp", i), 32'(rspv0), 32'(tbl[i].ers));
      chk($sformatf("v%0d_rdata", i), rd0, tbl[i].erd);
      if (tbl[i].r) chk($sformatf("v%0d_wea_rst", i), 32'(we0), 32'h0);
      model_step();
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 63) == 0,
            2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3)),
            2'($urandom), 2'($urandom),
            6'($urandom), 6'($urandom), $urandom, $urandom,
            4'($urandom), 4'($urandom));
      #4;
      model_step();
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
